// File: rtl/mat_result_reader.sv
// Snapshots the packed DIMxDIM int8 product and streams the active sub-matrix row-major.
// Optional macro TAG_EN adds rd_row/rd_col coordinate outputs.
module mat_result_reader #(
    parameter int ELEM_W = 8,
    parameter int DIM    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cap,
    input  logic [DIM*DIM*ELEM_W-1:0] n_in,
    input  logic                      ovf_in,
    input  logic [2:0]                size,
    output logic [ELEM_W-1:0]         rd_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic                      rd_last,
    output logic                      busy,
    output logic                      done,
    output logic                      ovf_flag
`ifdef TAG_EN
    ,
    output logic [2:0]                rd_row,
    output logic [2:0]                rd_col
`endif
);

    localparam int NEL = DIM * DIM;
    localparam int BW  = NEL * ELEM_W;
    localparam int IW  = $clog2(NEL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [BW-1:0]     r_shadow;
    logic [2:0]        r_size;
    logic [2:0]        r_row;
    logic [2:0]        r_col;
    logic              r_ovf;

    logic [2:0]        w_size_clamp;
    logic [2:0]        w_max;
    logic              w_send;
    logic              w_cap_ok;
    logic              w_beat;
    logic              w_at_end;
    logic [IW-1:0]     w_idx;
    logic [ELEM_W-1:0] w_elem [NEL];

    assign w_send   = (r_state == S_SEND);
    assign w_cap_ok = cap && !w_send;
    assign w_beat   = w_send && rd_ready;
    assign w_max    = r_size - 3'd1;
    assign w_at_end = (r_row == w_max) && (r_col == w_max);
    assign w_idx    = IW'(32'(r_row) * DIM + 32'(r_col));

    assign w_size_clamp = (size < 3'd2)      ? 3'd2 :
                          (size > 3'(DIM))   ? 3'(DIM) : size;

    // Element (r,c) lives at the MSB end of the bus for index 0.
    always_comb begin
        for (int i = 0; i < NEL; i++) begin
            w_elem[i] = r_shadow[BW-1-ELEM_W*i -: ELEM_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (cap) begin
                    w_next = S_SEND;
                end
            end
            S_SEND: begin
                if (w_beat && w_at_end) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_size   <= 3'd2;
            r_row    <= 3'd0;
            r_col    <= 3'd0;
            r_ovf    <= 1'b0;
        end else if (w_cap_ok) begin
            r_shadow <= n_in;
            r_size   <= w_size_clamp;
            r_row    <= 3'd0;
            r_col    <= 3'd0;
            r_ovf    <= ovf_in;
        end else if (w_beat && !w_at_end) begin
            if (r_col == w_max) begin
                r_col <= 3'd0;
                r_row <= r_row + 3'd1;
            end else begin
                r_col <= r_col + 3'd1;
            end
        end
    end

    // All outputs decode registered state only; rd_ready never reaches them.
    assign rd_valid = w_send;
    assign busy     = w_send;
    assign done     = (r_state == S_DONE);
    assign rd_data  = w_send ? w_elem[w_idx] : '0;
    assign rd_last  = w_send && w_at_end;
    assign ovf_flag = r_ovf;

`ifdef TAG_EN
    assign rd_row = w_send ? r_row : 3'd0;
    assign rd_col = w_send ? r_col : 3'd0;
`endif

endmodule
